// File: rtl/multicycle_ctrl_pkg.sv
// Shared constants and state encoding for the multicycle MIPS control FSM.
package multicycle_ctrl_pkg;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ORI  = 6'b001101;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;
    localparam logic [1:0] ALU_OP_OR    = 2'b11;

    localparam logic [1:0] PC_SRC_SEQ = 2'b00;
    localparam logic [1:0] PC_SRC_BR  = 2'b01;
    localparam logic [1:0] PC_SRC_JMP = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_EXEC_I   = 4'd3,
        S_MEM_ADDR = 4'd4,
        S_MEM_RD   = 4'd5,
        S_MEM_WR   = 4'd6,
        S_BRANCH   = 4'd7,
        S_JUMP     = 4'd8,
        S_TRAP     = 4'd15
    } state_t;

    function automatic logic op_legal(input logic [5:0] op);
        case (op)
            OP_R, OP_LW, OP_SW, OP_BEQ,
            OP_J, OP_ADDI, OP_ORI: return 1'b1;
            default:               return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_ctrl_mem_wait_timer.sv
// Wait-cycle counter shared by the memory wait states; flags the
// last permitted not-ready cycle so the FSM can trap.
module mem_wait_timer #(
    parameter int WAIT_LIMIT = 16,
    parameter int CNT_W      = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic wait_i,
    output logic expired_o
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WAIT_LIMIT - 1);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            cnt_q <= '0;
        end else if (wait_i && cnt_q != LAST) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // cnt_q holds the not-ready cycles already seen, so this one is the last
    assign expired_o = wait_i && (cnt_q == LAST);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS main control FSM with variable-latency memory
// handshakes and sticky illegal/timeout traps.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int WAIT_LIMIT = 16,
    parameter int CNT_W      = 8
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [5:0] op_i,
    input  logic       zero_i,
    input  logic       imem_ready_i,
    input  logic       dmem_ready_i,
    output logic       imem_req_o,
    output logic       ir_we_o,
    output logic       pc_we_o,
    output logic [1:0] pc_src_o,
    output logic       reg_write_o,
    output logic       reg_dst_o,
    output logic       mem_to_reg_o,
    output logic       alu_src_o,
    output logic       ext_op_o,
    output logic [1:0] alu_op_o,
    output logic       dmem_read_o,
    output logic       dmem_write_o,
    output logic       illegal_o,
    output logic       timeout_o,
    output logic [3:0] state_o
);

    state_t state_q, state_d;
    logic   illegal_q, timeout_q;
    logic   set_ill, set_to;
    logic   wait_st, ready, expired;

    assign wait_st = (state_q == S_FETCH) || (state_q == S_MEM_RD)
                  || (state_q == S_MEM_WR);
    assign ready   = (state_q == S_FETCH) ? imem_ready_i : dmem_ready_i;

    mem_wait_timer #(
        .WAIT_LIMIT (WAIT_LIMIT),
        .CNT_W      (CNT_W)
    ) u_timer (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clr_i     (state_d != state_q),
        .wait_i    (wait_st && !ready),
        .expired_o (expired)
    );

    always_comb begin
        state_d      = state_q;
        set_ill      = 1'b0;
        set_to       = 1'b0;
        imem_req_o   = 1'b0;
        ir_we_o      = 1'b0;
        pc_we_o      = 1'b0;
        pc_src_o     = PC_SRC_SEQ;
        reg_write_o  = 1'b0;
        reg_dst_o    = 1'b0;
        mem_to_reg_o = 1'b0;
        alu_src_o    = 1'b0;
        ext_op_o     = 1'b0;
        alu_op_o     = ALU_OP_ADD;
        dmem_read_o  = 1'b0;
        dmem_write_o = 1'b0;
        case (state_q)
            S_FETCH: begin
                imem_req_o = 1'b1;
                if (imem_ready_i) begin
                    ir_we_o = 1'b1;
                    pc_we_o = 1'b1;
                    state_d = S_DECODE;
                end else if (expired) begin
                    set_to  = 1'b1;
                    state_d = S_TRAP;
                end
            end
            S_DECODE: begin
                if (!op_legal(op_i)) begin
                    set_ill = 1'b1;
                    state_d = S_TRAP;
                end else begin
                    case (op_i)
                        OP_R:             state_d = S_EXEC_R;
                        OP_ADDI, OP_ORI:  state_d = S_EXEC_I;
                        OP_LW, OP_SW:     state_d = S_MEM_ADDR;
                        OP_BEQ:           state_d = S_BRANCH;
                        default:          state_d = S_JUMP;
                    endcase
                end
            end
            S_EXEC_R: begin
                alu_op_o    = ALU_OP_FUNCT;
                reg_dst_o   = 1'b1;
                reg_write_o = 1'b1;
                state_d     = S_FETCH;
            end
            S_EXEC_I: begin
                alu_src_o   = 1'b1;
                reg_write_o = 1'b1;
                ext_op_o    = (op_i != OP_ORI);
                alu_op_o    = (op_i == OP_ORI) ? ALU_OP_OR : ALU_OP_ADD;
                state_d     = S_FETCH;
            end
            S_MEM_ADDR: begin
                alu_src_o = 1'b1;
                ext_op_o  = 1'b1;
                state_d   = (op_i == OP_SW) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD, S_MEM_WR: begin
                // address controls stay stable for the whole request
                alu_src_o    = 1'b1;
                ext_op_o     = 1'b1;
                dmem_read_o  = (state_q == S_MEM_RD);
                dmem_write_o = (state_q == S_MEM_WR);
                if (dmem_ready_i) begin
                    reg_write_o  = (state_q == S_MEM_RD);
                    mem_to_reg_o = (state_q == S_MEM_RD);
                    state_d      = S_FETCH;
                end else if (expired) begin
                    set_to  = 1'b1;
                    state_d = S_TRAP;
                end
            end
            S_BRANCH: begin
                alu_op_o = ALU_OP_SUB;
                pc_src_o = PC_SRC_BR;
                pc_we_o  = zero_i;
                state_d  = S_FETCH;
            end
            S_JUMP: begin
                pc_src_o = PC_SRC_JMP;
                pc_we_o  = 1'b1;
                state_d  = S_FETCH;
            end
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_TRAP;
        endcase
        if (rst_i) begin
            state_d      = S_FETCH;
            set_ill      = 1'b0;
            set_to       = 1'b0;
            imem_req_o   = 1'b0;
            ir_we_o      = 1'b0;
            pc_we_o      = 1'b0;
            pc_src_o     = PC_SRC_SEQ;
            reg_write_o  = 1'b0;
            reg_dst_o    = 1'b0;
            mem_to_reg_o = 1'b0;
            alu_src_o    = 1'b0;
            ext_op_o     = 1'b0;
            alu_op_o     = ALU_OP_ADD;
            dmem_read_o  = 1'b0;
            dmem_write_o = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (set_ill) illegal_q <= 1'b1;
            if (set_to)  timeout_q <= 1'b1;
        end
    end

    assign illegal_o = illegal_q;
    assign timeout_o = timeout_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: vector table, corner
// sequences and randomized instructions against a per-phase model.
module tb_multicycle_ctrl;

    localparam int WL = 16;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_BAD  = 6'b111111;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic [5:0] op_i = '0;
    logic       zero_i = 1'b0;
    logic       imem_ready_i = 1'b0;
    logic       dmem_ready_i = 1'b0;
    logic       imem_req_o, ir_we_o, pc_we_o;
    logic [1:0] pc_src_o;
    logic       reg_write_o, reg_dst_o, mem_to_reg_o;
    logic       alu_src_o, ext_op_o;
    logic [1:0] alu_op_o;
    logic       dmem_read_o, dmem_write_o;
    logic       illegal_o, timeout_o;
    logic [3:0] state_o;

    multicycle_ctrl #(
        .WAIT_LIMIT (WL),
        .CNT_W      (8)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .op_i         (op_i),
        .zero_i       (zero_i),
        .imem_ready_i (imem_ready_i),
        .dmem_ready_i (dmem_ready_i),
        .imem_req_o   (imem_req_o),
        .ir_we_o      (ir_we_o),
        .pc_we_o      (pc_we_o),
        .pc_src_o     (pc_src_o),
        .reg_write_o  (reg_write_o),
        .reg_dst_o    (reg_dst_o),
        .mem_to_reg_o (mem_to_reg_o),
        .alu_src_o    (alu_src_o),
        .ext_op_o     (ext_op_o),
        .alu_op_o     (alu_op_o),
        .dmem_read_o  (dmem_read_o),
        .dmem_write_o (dmem_write_o),
        .illegal_o    (illegal_o),
        .timeout_o    (timeout_o),
        .state_o      (state_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [3:0] st;
        logic       ireq, irwe, pcwe;
        logic [1:0] pcsrc;
        logic       rw, rdst, m2r, asrc, ext;
        logic [1:0] aop;
        logic       drd, dwr, ill, to;
    } obs_t;

    typedef struct {
        logic       r;
        logic [5:0] op;
        logic       z, ir, dr;
        obs_t       e;
    } vec_t;

    vec_t tbl[$];
    int   n_pass = 0;
    int   n_tot  = 0;
    logic m_ill  = 1'b0;
    logic m_to   = 1'b0;

    // expected per-phase controls, straight from the control table
    function automatic obs_t base(input logic [3:0] s);
        obs_t o = '0;
        o.st  = s;
        o.ill = m_ill;
        o.to  = m_to;
        return o;
    endfunction
    function automatic obs_t f_fetch(input logic rdy);
        obs_t o = base(4'd0);
        o.ireq = 1'b1; o.irwe = rdy; o.pcwe = rdy;
        return o;
    endfunction
    function automatic obs_t f_dec();
        return base(4'd1);
    endfunction
    function automatic obs_t f_exr();
        obs_t o = base(4'd2);
        o.aop = 2'b10; o.rdst = 1'b1; o.rw = 1'b1;
        return o;
    endfunction
    function automatic obs_t f_exi(input logic ori);
        obs_t o = base(4'd3);
        o.asrc = 1'b1; o.rw = 1'b1;
        o.aop  = ori ? 2'b11 : 2'b00;
        o.ext  = ~ori;
        return o;
    endfunction
    function automatic obs_t f_mad();
        obs_t o = base(4'd4);
        o.asrc = 1'b1; o.ext = 1'b1;
        return o;
    endfunction
    function automatic obs_t f_mrd(input logic rdy);
        obs_t o = base(4'd5);
        o.asrc = 1'b1; o.ext = 1'b1; o.drd = 1'b1;
        o.rw = rdy; o.m2r = rdy;
        return o;
    endfunction
    function automatic obs_t f_mwr();
        obs_t o = base(4'd6);
        o.asrc = 1'b1; o.ext = 1'b1; o.dwr = 1'b1;
        return o;
    endfunction
    function automatic obs_t f_br(input logic z);
        obs_t o = base(4'd7);
        o.aop = 2'b01; o.pcsrc = 2'b01; o.pcwe = z;
        return o;
    endfunction
    function automatic obs_t f_jmp();
        obs_t o = base(4'd8);
        o.pcsrc = 2'b10; o.pcwe = 1'b1;
        return o;
    endfunction
    function automatic obs_t f_trap();
        return base(4'd15);
    endfunction

    function automatic obs_t get_obs();
        obs_t o;
        o.st = state_o; o.ireq = imem_req_o; o.irwe = ir_we_o;
        o.pcwe = pc_we_o; o.pcsrc = pc_src_o; o.rw = reg_write_o;
        o.rdst = reg_dst_o; o.m2r = mem_to_reg_o; o.asrc = alu_src_o;
        o.ext = ext_op_o; o.aop = alu_op_o; o.drd = dmem_read_o;
        o.dwr = dmem_write_o; o.ill = illegal_o; o.to = timeout_o;
        return o;
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic int rlat();
        if ($urandom_range(0, 7) == 0) return $urandom_range(14, 17);
        return $urandom_range(0, 3);
    endfunction

    function automatic logic is_legal(input logic [5:0] op);
        return op == OP_R || op == OP_LW || op == OP_SW || op == OP_BEQ
            || op == OP_J || op == OP_ADDI || op == OP_ORI;
    endfunction

    task automatic add(input logic r, input logic [5:0] op,
                       input logic z, input logic ir, input logic dr,
                       input obs_t e);
        vec_t v;
        v.r = r; v.op = op; v.z = z; v.ir = ir; v.dr = dr; v.e = e;
        tbl.push_back(v);
    endtask

    // one cycle: drive after negedge, sample 1ns later, advance
    task automatic cyc(input logic r, input logic [5:0] op,
                       input logic z, input logic ir, input logic dr,
                       input obs_t e, input string nm);
        obs_t a;
        rst_i = r; op_i = op; zero_i = z;
        imem_ready_i = ir; dmem_ready_i = dr;
        #1;
        a = get_obs();
        n_tot++;
        if (a === e) n_pass++;
        else $display("FAIL %s: got %h want %h", nm, a, e);
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic do_reset(input logic [3:0] st);
        cyc(1'b1, OP_R, rb(), rb(), rb(), base(st), "reset cycle");
        m_ill = 1'b0;
        m_to  = 1'b0;
    endtask

    task automatic pre(input logic [5:0] op, input logic mem);
        cyc(1'b0, op, 1'b0, 1'b1, 1'b0, f_fetch(1'b1), "seq fetch");
        cyc(1'b0, op, 1'b0, 1'b0, 1'b0, f_dec(), "seq decode");
        if (mem) cyc(1'b0, op, 1'b0, 1'b0, 1'b0, f_mad(), "seq addr");
    endtask

    task automatic mem_phase(input logic lw, input logic [5:0] op,
                             input int lat);
        for (int k = 0; k < lat && k < WL; k++)
            cyc(1'b0, op, rb(), rb(), 1'b0,
                lw ? f_mrd(1'b0) : f_mwr(), "rnd mem wait");
        if (lat >= WL) begin
            m_to = 1'b1;
            cyc(1'b0, op, rb(), rb(), rb(), f_trap(), "rnd mem timeout");
            do_reset(4'd15);
        end else begin
            cyc(1'b0, op, rb(), rb(), 1'b1,
                lw ? f_mrd(1'b1) : f_mwr(), "rnd mem done");
        end
    endtask

    task automatic run_instr(input logic [5:0] op, input int li,
                             input int ld);
        logic z;
        for (int k = 0; k < li && k < WL; k++)
            cyc(1'b0, op, rb(), 1'b0, rb(), f_fetch(1'b0), "rnd fetch wait");
        if (li >= WL) begin
            m_to = 1'b1;
            cyc(1'b0, op, rb(), rb(), rb(), f_trap(), "rnd fetch timeout");
            do_reset(4'd15);
            return;
        end
        cyc(1'b0, op, rb(), 1'b1, rb(), f_fetch(1'b1), "rnd fetch");
        cyc(1'b0, op, rb(), rb(), rb(), f_dec(), "rnd decode");
        if (!is_legal(op)) begin
            m_ill = 1'b1;
            repeat ($urandom_range(1, 3))
                cyc(1'b0, op, rb(), rb(), rb(), f_trap(), "rnd trap");
            do_reset(4'd15);
            return;
        end
        z = rb();
        case (op)
            OP_R:    cyc(1'b0, op, z, rb(), rb(), f_exr(), "rnd exec r");
            OP_ADDI: cyc(1'b0, op, z, rb(), rb(), f_exi(1'b0), "rnd addi");
            OP_ORI:  cyc(1'b0, op, z, rb(), rb(), f_exi(1'b1), "rnd ori");
            OP_BEQ:  cyc(1'b0, op, z, rb(), rb(), f_br(z), "rnd beq");
            OP_J:    cyc(1'b0, op, z, rb(), rb(), f_jmp(), "rnd jump");
            default: begin
                cyc(1'b0, op, z, rb(), rb(), f_mad(), "rnd addr");
                mem_phase(op == OP_LW, op, ld);
            end
        endcase
    endtask

    initial begin
        logic [5:0] legal [7];
        logic [5:0] op;
        legal = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI, OP_ORI};

        add(1, OP_R,    0, 1, 0, base(4'd0));
        add(0, OP_R,    0, 1, 0, f_fetch(1));
        add(0, OP_R,    0, 1, 0, f_dec());
        add(0, OP_R,    0, 1, 0, f_exr());
        add(0, OP_ORI,  0, 1, 0, f_fetch(1));
        add(0, OP_ORI,  0, 1, 0, f_dec());
        add(0, OP_ORI,  0, 1, 0, f_exi(1));
        add(0, OP_ADDI, 0, 1, 0, f_fetch(1));
        add(0, OP_ADDI, 0, 1, 0, f_dec());
        add(0, OP_ADDI, 0, 1, 0, f_exi(0));
        add(0, OP_BEQ,  1, 1, 0, f_fetch(1));
        add(0, OP_BEQ,  1, 1, 0, f_dec());
        add(0, OP_BEQ,  1, 1, 0, f_br(1));
        add(0, OP_BEQ,  0, 1, 0, f_fetch(1));
        add(0, OP_BEQ,  0, 1, 0, f_dec());
        add(0, OP_BEQ,  0, 1, 0, f_br(0));
        add(0, OP_J,    0, 1, 1, f_fetch(1));
        add(0, OP_J,    0, 1, 1, f_dec());
        add(0, OP_J,    0, 1, 1, f_jmp());
        add(0, OP_SW,   0, 1, 1, f_fetch(1));
        add(0, OP_SW,   0, 1, 1, f_dec());
        add(0, OP_SW,   0, 1, 1, f_mad());
        add(0, OP_SW,   0, 1, 1, f_mwr());
        add(0, OP_LW,   0, 1, 1, f_fetch(1));
        add(0, OP_LW,   0, 1, 1, f_dec());
        add(0, OP_LW,   0, 1, 1, f_mad());
        add(0, OP_LW,   0, 1, 1, f_mrd(1));

        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        foreach (tbl[i])
            cyc(tbl[i].r, tbl[i].op, tbl[i].z, tbl[i].ir, tbl[i].dr,
                tbl[i].e, $sformatf("tbl[%0d]", i));

        // LW with data ready on the fourth MEM_RD cycle
        pre(OP_LW, 1'b1);
        for (int k = 0; k < 3; k++)
            cyc(0, OP_LW, 0, 1, 0, f_mrd(1'b0), "lw wait");
        cyc(0, OP_LW, 0, 1, 1, f_mrd(1'b1), "lw ready");
        cyc(0, OP_R, 0, 0, 0, f_fetch(1'b0), "lw back to fetch");

        // illegal opcode traps and holds until reset
        pre(OP_BAD, 1'b0);
        m_ill = 1'b1;
        repeat (20) cyc(0, OP_BAD, rb(), rb(), rb(), f_trap(), "trap hold");
        do_reset(4'd15);

        // SW never ready: 16 wait cycles then timeout trap
        pre(OP_SW, 1'b1);
        for (int k = 0; k < WL; k++)
            cyc(0, OP_SW, 0, 0, 0, f_mwr(), "sw wait");
        m_to = 1'b1;
        cyc(0, OP_SW, 0, 0, 0, f_trap(), "sw timeout");
        do_reset(4'd15);

        // SW ready on the limit cycle wins
        pre(OP_SW, 1'b1);
        for (int k = 0; k < WL - 1; k++)
            cyc(0, OP_SW, 0, 0, 0, f_mwr(), "sw wait2");
        cyc(0, OP_SW, 0, 0, 1, f_mwr(), "sw ready at limit");
        cyc(0, OP_SW, 0, 0, 0, f_fetch(1'b0), "sw limit back to fetch");

        // reset in the middle of a data wait
        cyc(0, OP_SW, 0, 1, 0, f_fetch(1'b1), "mid fetch");
        cyc(0, OP_SW, 0, 0, 0, f_dec(), "mid decode");
        cyc(0, OP_SW, 0, 0, 0, f_mad(), "mid addr");
        for (int k = 0; k < 5; k++)
            cyc(0, OP_SW, 0, 0, 0, f_mwr(), "mid wait");
        do_reset(4'd6);
        cyc(0, OP_R, 0, 1, 0, f_fetch(1'b1), "after mid reset");
        cyc(0, OP_R, 0, 0, 0, f_dec(), "after mid decode");
        cyc(0, OP_R, 0, 0, 0, f_exr(), "after mid exec");

        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 15) == 0) begin
                op = 6'($urandom_range(0, 63));
                while (is_legal(op)) op = 6'($urandom_range(0, 63));
            end else begin
                op = legal[$urandom_range(0, 6)];
            end
            run_instr(op, rlat(), rlat());
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
